cfi_shadow_stack_commit: RTL

Commit-time control-flow integrity monitor, a parametrised successor to the single-port nop/CFI parser. It sits beside `commit_stage` and observes every acknowledged commit port in order. It keeps a circular hardware shadow return-address stack of configurable depth and checks each return against the PC of the next committed instruction. In ENFORCE mode a mismatch raises a registered exception towards the commit stage.

---
 rtl/cfi_shadow_stack_commit_pkg.sv | 94 +++++++++
 rtl/cfi_shadow_stack_commit_ras_ram.sv | 69 ++++++
 rtl/cfi_shadow_stack_commit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/cfi_shadow_stack_commit_pkg.sv
// Shared types for the commit-time CFI shadow stack monitor.
// Scoreboard/exception subset plus CFI enums and classifier helpers.
package cfi_shadow_stack_commit_pkg;

  localparam int unsigned VLEN = 32;
  localparam int unsigned XLEN = 32;

  // Custom cause from the 24-31 designated range.
  localparam logic [XLEN-1:0] CFI_VIOLATION_CAUSE = 32'd24;

  typedef enum logic [1:0] {
    CFI_OFF     = 2'b00,
    CFI_MONITOR = 2'b01,
    CFI_ENFORCE = 2'b10,
    CFI_RSVD    = 2'b11
  } cfi_mode_e;

  typedef enum logic [1:0] {
    KIND_NONE,
    KIND_CALL,
    KIND_RET,
    KIND_CORO
  } cfi_kind_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PEND,
    S_FAULT
  } cfi_state_e;

  typedef enum logic [2:0] {
    FU_NONE,
    LOAD,
    STORE,
    ALU,
    CTRL_FLOW,
    CSR
  } fu_t;

  typedef enum logic [3:0] {
    ADD,
    SUB,
    JAL,
    JALR,
    EQ,
    NE
  } fu_op;

  typedef struct packed {
    logic [VLEN-1:0] pc;
    fu_t             fu;
    fu_op            op;
    logic [4:0]      rs1;
    logic [4:0]      rd;
    logic            is_compressed;
    logic            valid;
  } scoreboard_entry_t;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  function automatic logic is_link(logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  function automatic cfi_kind_e classify(
    fu_t fu, fu_op op, logic [4:0] rd, logic [4:0] rs1
  );
    logic rd_l;
    logic rs_l;
    rd_l = is_link(rd);
    rs_l = is_link(rs1);
    classify = KIND_NONE;
    if (fu == CTRL_FLOW) begin
      if (op == JAL && rd_l) begin
        classify = KIND_CALL;
      end else if (op == JALR) begin
        if (rd_l && rs_l && rd != rs1) classify = KIND_CORO;
        else if (rd_l)                 classify = KIND_CALL;
        else if (rs_l)                 classify = KIND_RET;
      end
    end
  endfunction

  function automatic logic [VLEN-1:0] link_addr(
    logic [VLEN-1:0] pc, logic c
  );
    return c ? pc + VLEN'(2) : pc + VLEN'(4);
  endfunction

endpackage

// File: rtl/cfi_shadow_stack_commit_ras_ram.sv
// Circular shadow return-address stack, several ordered ops per cycle.
// A full stack overwrites its oldest entry on push.
module cfi_shadow_stack_commit_ras_ram
  import cfi_shadow_stack_commit_pkg::*;
#(
  parameter int unsigned NP    = 2,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic [NP-1:0]            push_i,
  input  logic [NP-1:0]            pop_i,
  input  logic [NP-1:0][VLEN-1:0]  push_data_i,
  output logic [NP-1:0][VLEN-1:0]  pop_data_o,
  output logic [NP-1:0]            pop_valid_o,
  output logic [AW:0]              occ_o
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [VLEN-1:0] mem_q [DEPTH];
  logic [VLEN-1:0] mem_d [DEPTH];
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [AW:0]     occ_q, occ_d;

  // Ops are applied port by port so same-cycle push/pop see each other.
  always_comb begin
    mem_d       = mem_q;
    ptr_d       = ptr_q;
    occ_d       = occ_q;
    pop_data_o  = '0;
    pop_valid_o = '0;
    if (clear_i) begin
      ptr_d = '0;
      occ_d = '0;
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (pop_i[i] && occ_d != '0) begin
          ptr_d          = ptr_d - 1'b1;
          occ_d          = occ_d - 1'b1;
          pop_valid_o[i] = 1'b1;
          pop_data_o[i]  = mem_d[ptr_d];
        end
        if (push_i[i]) begin
          mem_d[ptr_d] = push_data_i[i];
          ptr_d        = ptr_d + 1'b1;
          if (occ_d != FULL) occ_d = occ_d + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      occ_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      occ_q <= occ_d;
      mem_q <= mem_d;
    end
  end

  assign occ_o = occ_q;

endmodule

// File: rtl/cfi_shadow_stack_commit.sv
// Commit-time CFI monitor: classifies commits, checks returns against
// the next committed pc, and raises a registered exception on mismatch.
module cfi_shadow_stack_commit
  import cfi_shadow_stack_commit_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned DEPTH           = 16,
  parameter int unsigned STRICT          = 0,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     flush_i,
  input  logic [1:0]                               mode_i,
  input  scoreboard_entry_t [NR_COMMIT_PORTS-1:0]  commit_instr_i,
  input  logic [NR_COMMIT_PORTS-1:0]               commit_ack_i,
  output exception_t                               exception_o,
  output logic                                     cfi_signal_o,
  output logic [CNT_W-1:0]                         viol_cnt_o,
  output logic [$clog2(DEPTH):0]                   sp_o
);

  localparam int unsigned NP = NR_COMMIT_PORTS;
  localparam int unsigned AW = $clog2(DEPTH);

  cfi_mode_e  mode;
  logic       off;
  logic       enforce;

  logic [NP-1:0]            active, push, pop, pop_valid;
  logic [NP-1:0][VLEN-1:0]  push_data, pop_data;

  cfi_state_e       state_q, state_d;
  logic [VLEN-1:0]  tgt_q, tgt_d;
  logic [VLEN-1:0]  tval_q, tval_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sig_q, sig_d;

  logic             pend;
  logic             viol;
  logic [VLEN-1:0]  vtval;

  assign mode    = cfi_mode_e'(mode_i);
  assign off     = (mode == CFI_OFF);
  assign enforce = (mode == CFI_ENFORCE) || (mode == CFI_RSVD);

  always_comb begin
    cfi_kind_e k;
    active    = '0;
    push      = '0;
    pop       = '0;
    push_data = '0;
    for (int i = 0; i < NP; i++) begin
      k = KIND_NONE;
      if (!off && commit_instr_i[i].valid && commit_ack_i[i]) begin
        active[i] = 1'b1;
        k = classify(commit_instr_i[i].fu, commit_instr_i[i].op,
                     commit_instr_i[i].rd, commit_instr_i[i].rs1);
      end
      push[i]      = (k == KIND_CALL) || (k == KIND_CORO);
      pop[i]       = (k == KIND_RET)  || (k == KIND_CORO);
      push_data[i] = link_addr(commit_instr_i[i].pc,
                               commit_instr_i[i].is_compressed);
    end
  end

  cfi_shadow_stack_commit_ras_ram #(
    .NP    (NP),
    .DEPTH (DEPTH)
  ) u_ras (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (off),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (push_data),
    .pop_data_o  (pop_data),
    .pop_valid_o (pop_valid),
    .occ_o       (sp_o)
  );

  // Compare chain: the first active port after a return checks its pc.
  always_comb begin
    pend  = (state_q == S_PEND);
    tgt_d = tgt_q;
    viol  = 1'b0;
    vtval = '0;
    for (int i = 0; i < NP; i++) begin
      if (active[i] && state_q != S_FAULT) begin
        if (pend) begin
          pend = 1'b0;
          if (commit_instr_i[i].pc != tgt_d) begin
            if (!viol) vtval = commit_instr_i[i].pc;
            viol = 1'b1;
          end
        end
        if (pop[i]) begin
          if (pop_valid[i]) begin
            pend  = 1'b1;
            tgt_d = pop_data[i];
          end else if (STRICT != 0) begin
            if (!viol) vtval = commit_instr_i[i].pc;
            viol = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    tval_d  = tval_q;
    cnt_d   = cnt_q;
    sig_d   = viol;
    if (viol && cnt_q != '1) cnt_d = cnt_q + 1'b1;
    if (off) begin
      state_d = S_IDLE;
    end else if (state_q == S_FAULT) begin
      if (flush_i) state_d = S_IDLE;
    end else if (viol && enforce) begin
      state_d = S_FAULT;
      tval_d  = vtval;
    end else if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      state_d = pend ? S_PEND : S_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      tgt_q   <= '0;
      tval_q  <= '0;
      cnt_q   <= '0;
      sig_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= off ? '0 : tgt_d;
      tval_q  <= tval_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
    end
  end

  always_comb begin
    exception_o = '0;
    if (state_q == S_FAULT) begin
      exception_o.valid = 1'b1;
      exception_o.cause = CFI_VIOLATION_CAUSE;
      exception_o.tval  = tval_q;
    end
  end

  assign cfi_signal_o = sig_q;
  assign viol_cnt_o   = cnt_q;

endmodule
